barcode_check_digit_seq: RTL and testbench
==========================================

Name: barcode_check_digit_seq

Overview:
- Sequential, parametrised check-digit engine for the barcode generator.
- Computes checkDigit = (SEED + valueToPay + sum of weighted payload digits) mod MODULUS.
- Accepts valueToPay on a start handshake and then an optional serial stream of decimal payload digits.
- Reduction is iterative (one subtraction per cycle, no divider); the result feeds the barcode formatter.

Parameters:
- VALUE_W, 5, width of valueToPay.
- DIGIT_W, 4, width of one payload digit.
- MODULUS, 15, check modulus; must be ≥ 2.
- SEED, 54, constant digit sum of the team ID numbers.
- MAX_DIGIT, 9, largest legal payload digit.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a new computation; accepted only when startReady=1.
- startReady  out  1  high in IDLE and DONE.
- valueToPay  in  VALUE_W  amount in euros, sampled on start acceptance.
- noDigits  in  1  sampled with start; 1 = no payload digits follow.
- digitValid  in  1  payload digit present.
- digitReady  out  1  high only in WAIT_DIGIT.
- digit  in  DIGIT_W  payload digit.
- digitLast  in  1  marks the final payload digit.
- checkDigit  out  $clog2(MODULUS)  result; held until the next start acceptance.
- done  out  1  one-cycle pulse on entry to DONE.
- error  out  1  result invalid; held with checkDigit.

Behaviour:
- Internal accumulator sum, width SUM_W = $clog2(max(SEED+2^VALUE_W, MODULUS+3*(2^DIGIT_W))) + 1.
- Reset: state=IDLE; sum, checkDigit, error, done, digit position all 0; startReady=1; digitReady=0.
- Reset has priority over every other input, including mid-REDUCE or mid-stream; a partial result is discarded.
- States and transitions:
  - IDLE/DONE: on start (start & startReady):
    - sum ← SEED + valueToPay; error ← 0; position ← 0.
    - Latch noDigits as lastSeen; go to REDUCE.
  - REDUCE: each cycle, if sum ≥ MODULUS then sum ← sum − MODULUS; otherwise leave REDUCE.
    - If lastSeen=1, go to DONE.
    - Else go to WAIT_DIGIT.
  - WAIT_DIGIT: on digitValid & digitReady:
    - sum ← sum + w·digit; position toggles; lastSeen ← digitLast.
    - If digit > MAX_DIGIT, error ← 1 (stream continues to digitLast).
    - Go to REDUCE.
  - DONE:
    - On entry: checkDigit ← sum[..] and done=1 for one cycle.
    - If error=1, or valueToPay sampled was 0, then checkDigit ← 0 and error=1.
- Weight w = 1 unless WEIGHTED_EN is defined.
- Latency: start acceptance → done = 1 + ⌊(SEED+valueToPay)/MODULUS⌋ + 1 cycles when noDigits=1.
- Each digit adds 1 + (reductions needed) cycles.
- start while busy (REDUCE/WAIT_DIGIT) is ignored; startReady=0.
- digitValid outside WAIT_DIGIT is ignored; digitReady=0 back-pressures the source.
- start asserted in the same cycle as entry to DONE is not accepted until the next cycle (startReady is registered).

Optional Feature:
- Macro: BARCODE_WEIGHTED_EN.
- Defined: EAN-style weighting.
  - Digits at even positions (0, 2, …) use w=3 (digit+(digit<<1)); odd positions use w=1.
  - REDUCE may take up to 3 extra cycles per digit.
- Undefined: w=1 for all digits; the position toggle logic is removed.

Decomposition:
- Package barcode_pkg:
  - state enum (IDLE, REDUCE, WAIT_DIGIT, DONE).
  - default SEED/MODULUS constants.
  - SUM_W computation function.
- Optional sub-module barcode_mod_reduce: holds the compare-and-subtract step.
  - Purely combinational: sum in → next sum, doneReduce out.
  - Lets the same step be reused by the later price-encoder block.
- The FSM and registers stay in the top module.

Test Plan:
- reset; start, valueToPay=2, noDigits=1 → done after 5 cycles, checkDigit=11, error=0 (56 mod 15).
- start, valueToPay=20, noDigits=1 → done after 6 cycles, checkDigit=14.
- Digit stream, weighting off:
  - Stimulus: start, valueToPay=6, noDigits=0; digits 3, 4(last); digitValid held high throughout.
  - digitReady low during REDUCE; checkDigit=7 (60+7=67 mod 15).
- Zero value / illegal digit:
  - valueToPay=0, noDigits=1 → checkDigit=0, error=1.
  - Separately: valueToPay=2, digit 12(last) → error=1, checkDigit=0.
- Reset mid-operation:
  - Assert reset during REDUCE of valueToPay=28 → next cycle IDLE, startReady=1, done never pulses.
  - A fresh valueToPay=24 run → checkDigit=3.
- Weighted mode (BARCODE_WEIGHTED_EN):
  - Stimulus: valueToPay=2, digits 1, 2(last).
  - sum = 56 + 3 + 2 = 61 → checkDigit=1.

Source files
------------

// File: rtl/barcode_pkg.sv
// barcode_pkg: shared state encoding, default constants and accumulator sizing for the barcode engines
package barcode_pkg;
  typedef enum logic [1:0] {IDLE, REDUCE, WAIT_DIGIT, DONE} state_t;
  localparam int DEFAULT_SEED = 54;
  localparam int DEFAULT_MODULUS = 15;
  function automatic int sum_width(input int seed, input int modulus, input int value_w, input int digit_w);
    int a, b;
    a = seed + (1 << value_w);
    b = modulus + 3 * (1 << digit_w);
    return $clog2(a > b ? a : b) + 1;
  endfunction
endpackage

// File: rtl/barcode_mod_reduce.sv
// barcode_mod_reduce: one compare-and-subtract step of an iterative modulo reduction
module barcode_mod_reduce #(
  parameter int SUM_W = 8,
  parameter int MODULUS = 15
) (
  input  logic [SUM_W-1:0] sum_i,
  output logic [SUM_W-1:0] sum_o,
  output logic             doneReduce_o
);
  assign doneReduce_o = sum_i < SUM_W'(MODULUS);
  // subtract the modulus only while the sum is still out of range
  always_comb sum_o = doneReduce_o ? sum_i : sum_i - SUM_W'(MODULUS);
endmodule

// File: rtl/barcode_check_digit_seq.sv
// barcode_check_digit_seq: sequential check-digit engine (SEED + value + weighted digits) mod MODULUS; BARCODE_WEIGHTED_EN enables EAN weighting
module barcode_check_digit_seq
  import barcode_pkg::*;
#(
  parameter int VALUE_W = 5,
  parameter int DIGIT_W = 4,
  parameter int MODULUS = DEFAULT_MODULUS,
  parameter int SEED = DEFAULT_SEED,
  parameter int MAX_DIGIT = 9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       startReady,
  input  logic [VALUE_W-1:0]         valueToPay,
  input  logic                       noDigits,
  input  logic                       digitValid,
  output logic                       digitReady,
  input  logic [DIGIT_W-1:0]         digit,
  input  logic                       digitLast,
  output logic [$clog2(MODULUS)-1:0] checkDigit,
  output logic                       done,
  output logic                       error
);
  localparam int CD_W = $clog2(MODULUS);
  localparam int SUM_W = sum_width(SEED, MODULUS, VALUE_W, DIGIT_W);
  state_t state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d, red_sum, addend;
  logic [CD_W-1:0] cd_q, cd_d;
  logic red_done, last_q, last_d, bad_q, bad_d, err_q, err_d, done_q, done_d;
  logic start_acc, digit_acc;
  assign start_acc = start & startReady;
  assign digit_acc = digitValid & digitReady;
  barcode_mod_reduce #(.SUM_W(SUM_W), .MODULUS(MODULUS)) u_reduce (
    .sum_i(sum_q),
    .sum_o(red_sum),
    .doneReduce_o(red_done)
  );
`ifdef BARCODE_WEIGHTED_EN
  logic pos_q, pos_d;
  // even positions weigh 3, odd positions weigh 1; position restarts with every computation
  always_comb begin
    pos_d = start_acc ? 1'b0 : digit_acc ? ~pos_q : pos_q;
    addend = pos_q ? SUM_W'(digit) : SUM_W'(digit) + (SUM_W'(digit) << 1);
  end
  // digit position register
  always_ff @(posedge clk) pos_q <= reset ? 1'b0 : pos_d;
`else
  // every digit weighs 1
  always_comb addend = SUM_W'(digit);
`endif
  // state register
  always_ff @(posedge clk) state_q <= reset ? IDLE : state_d;
  // next-state logic: reduce after every load, then fetch another digit or finish
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = start_acc ? REDUCE : state_q;
      REDUCE:     state_d = red_done ? (last_q ? DONE : WAIT_DIGIT) : REDUCE;
      WAIT_DIGIT: state_d = digit_acc ? REDUCE : WAIT_DIGIT;
      default:    state_d = IDLE;
    endcase
  end
  // handshake outputs decoded from the registered state
  always_comb begin
    startReady = state_q == IDLE || state_q == DONE;
    digitReady = state_q == WAIT_DIGIT;
  end
  // datapath next-state: load, reduce, accumulate digits, publish result on entry to DONE
  always_comb begin
    sum_d = sum_q;
    last_d = last_q;
    bad_d = bad_q;
    err_d = err_q;
    cd_d = cd_q;
    done_d = 1'b0;
    if (start_acc) begin
      sum_d = SUM_W'(SEED) + SUM_W'(valueToPay);
      last_d = noDigits;
      bad_d = valueToPay == '0;
      err_d = 1'b0;
      cd_d = '0;
    end else if (state_q == REDUCE) begin
      sum_d = red_sum;
      if (red_done && last_q) begin
        done_d = 1'b1;
        err_d = bad_q;
        cd_d = bad_q ? '0 : sum_q[CD_W-1:0];
      end
    end else if (digit_acc) begin
      sum_d = sum_q + addend;
      last_d = digitLast;
      bad_d = bad_q | (digit > DIGIT_W'(MAX_DIGIT));
    end
  end
  // datapath registers; reset discards any partial result
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
      last_q <= 1'b0;
      bad_q <= 1'b0;
      err_q <= 1'b0;
      cd_q <= '0;
      done_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      last_q <= last_d;
      bad_q <= bad_d;
      err_q <= err_d;
      cd_q <= cd_d;
      done_q <= done_d;
    end
  end
  assign checkDigit = cd_q;
  assign done = done_q;
  assign error = err_q;
endmodule

// File: tb/tb_barcode_check_digit_seq.sv
// tb_barcode_check_digit_seq: table-driven, hand-written and randomized checks of the check-digit engine
module tb_barcode_check_digit_seq;
  localparam int M = 15;
  localparam int SEED = 54;
`ifdef BARCODE_WEIGHTED_EN
  localparam int WEIGHTED = 1;
`else
  localparam int WEIGHTED = 0;
`endif
  logic clk = 1'b0;
  logic reset, start, noDigits, digitValid, digitLast;
  logic startReady, digitReady, done, error;
  logic [4:0] valueToPay;
  logic [3:0] digit, checkDigit;
  always #5 clk = ~clk;

  barcode_check_digit_seq dut (
    .clk(clk), .reset(reset), .start(start), .startReady(startReady),
    .valueToPay(valueToPay), .noDigits(noDigits), .digitValid(digitValid),
    .digitReady(digitReady), .digit(digit), .digitLast(digitLast),
    .checkDigit(checkDigit), .done(done), .error(error)
  );

  typedef struct {int v; int n; int d[4]; int cd; int err; int lat;} vec_t;
  vec_t tbl[9];
  int n_cmp = 0, n_bad = 0;
  int dq[8];
  int dn;
  int r_cd, r_err, r_lat, r_rdy;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // reference: the check digit from plain arithmetic, latency from the reduction counts
  task automatic model(input int v, output int cd, output int err, output int lat);
    int s, w;
    bit bad;
    s = SEED + v;
    bad = v == 0;
    lat = 2 + s / M;
    s = s % M;
    for (int k = 0; k < dn; k++) begin
      w = (WEIGHTED != 0 && k % 2 == 0) ? 3 : 1;
      if (dq[k] > 9) bad = 1;
      s += w * dq[k];
      lat += 2 + s / M;
      s = s % M;
    end
    cd = bad ? 0 : s;
    err = bad ? 1 : 0;
  endtask

  task automatic run_txn(input int v, input bit hold);
    int k, cyc, tmo;
    bit acc;
    k = 0;
    tmo = 0;
    r_rdy = 0;
    while (!startReady && tmo < 200) begin
      @(posedge clk); #1;
      tmo++;
    end
    if (tmo >= 200) chk("start_ready_wait", 0, 1);
    start = 1;
    valueToPay = v[4:0];
    noDigits = dn == 0;
    digitValid = dn > 0;
    digit = dn > 0 ? dq[0][3:0] : 4'd0;
    digitLast = dn == 1;
    @(posedge clk); #1;
    if (!hold) start = 0;
    cyc = 1;
    while (!done && cyc < 1000) begin
      if (digitReady) r_rdy++;
      acc = digitReady && digitValid;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        k++;
        if (k < dn) begin
          digit = dq[k][3:0];
          digitLast = k == dn - 1;
        end else begin
          digitValid = 0;
          digitLast = 0;
        end
      end
    end
    r_lat = cyc;
    r_cd = int'(checkDigit);
    r_err = int'(error);
  endtask

  initial begin
    int e_cd, e_err, e_lat, seen;
    reset = 1; start = 0; valueToPay = 0; noDigits = 0;
    digitValid = 0; digit = 0; digitLast = 0;
    tbl[0] = '{2, 0, '{0, 0, 0, 0}, 11, 0, 5};
    tbl[1] = '{20, 0, '{0, 0, 0, 0}, 14, 0, 6};
    tbl[2] = '{6, 2, '{3, 4, 0, 0}, WEIGHTED ? 13 : 7, 0, 10};
    tbl[3] = '{0, 0, '{0, 0, 0, 0}, 0, 1, 5};
    tbl[4] = '{2, 1, '{12, 0, 0, 0}, 0, 1, WEIGHTED ? 10 : 8};
    tbl[5] = '{24, 0, '{0, 0, 0, 0}, 3, 0, 7};
    tbl[6] = '{31, 0, '{0, 0, 0, 0}, 10, 0, 7};
    tbl[7] = '{1, 3, '{9, 9, 9, 0}, WEIGHTED ? 13 : 7, 0, WEIGHTED ? 15 : 13};
    tbl[8] = '{2, 2, '{1, 2, 0, 0}, WEIGHTED ? 1 : 14, 0, WEIGHTED ? 10 : 9};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_startReady", int'(startReady), 1);
    chk("reset_digitReady", int'(digitReady), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_checkDigit", int'(checkDigit), 0);
    chk("reset_error", int'(error), 0);
    reset = 0;

    foreach (tbl[i]) begin
      dn = tbl[i].n;
      for (int k = 0; k < 4; k++) dq[k] = tbl[i].d[k];
      run_txn(tbl[i].v, 0);
      chk($sformatf("tbl%0d_checkDigit", i), r_cd, tbl[i].cd);
      chk($sformatf("tbl%0d_error", i), r_err, tbl[i].err);
      chk($sformatf("tbl%0d_latency", i), r_lat, tbl[i].lat);
      chk($sformatf("tbl%0d_digitReady_cycles", i), r_rdy, tbl[i].n);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_done_one_cycle", i), int'(done), 0);
      chk($sformatf("tbl%0d_checkDigit_held", i), int'(checkDigit), tbl[i].cd);
    end

    dn = 0;
    start = 1; valueToPay = 5'd28; noDigits = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("midreset_startReady", int'(startReady), 1);
    chk("midreset_digitReady", int'(digitReady), 0);
    chk("midreset_checkDigit", int'(checkDigit), 0);
    chk("midreset_error", int'(error), 0);
    seen = 0;
    repeat (12) begin
      if (done) seen = 1;
      @(posedge clk); #1;
    end
    chk("midreset_no_done", seen, 0);
    run_txn(24, 0);
    chk("after_reset_checkDigit", r_cd, 3);
    chk("after_reset_latency", r_lat, 7);

    dn = 0;
    run_txn(20, 1);
    chk("busy_start_checkDigit", r_cd, 14);
    chk("busy_start_latency", r_lat, 6);
    @(posedge clk); #1;
    chk("restart_from_done_startReady", int'(startReady), 0);
    chk("restart_from_done_done", int'(done), 0);
    start = 0;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    chk("restart_done_seen", seen, 1);
    chk("restart_checkDigit", int'(checkDigit), 14);

    for (int t = 0; t < 40; t++) begin
      int v;
      v = int'($urandom_range(0, 31));
      dn = int'($urandom_range(0, 4));
      for (int k = 0; k < dn; k++)
        dq[k] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
      model(v, e_cd, e_err, e_lat);
      run_txn(v, 0);
      chk($sformatf("rnd%0d_checkDigit", t), r_cd, e_cd);
      chk($sformatf("rnd%0d_error", t), r_err, e_err);
      chk($sformatf("rnd%0d_latency", t), r_lat, e_lat);
      chk($sformatf("rnd%0d_digitReady_cycles", t), r_rdy, dn);
      @(posedge clk); #1;
      chk($sformatf("rnd%0d_done_one_cycle", t), int'(done), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
